// File: rtl/muldiv_unit_pkg.sv
// Shared constants, FSM encoding and helpers for the rysy RV32M multiply/divide unit.
// Supplies the default register width when the core has not already defined `REG_LEN.
`ifndef REG_LEN
`define REG_LEN 32
`endif

package muldiv_unit_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  localparam int MULDIV_CYCLES = `REG_LEN;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic [`REG_LEN-1:0] magnitude(input logic [`REG_LEN-1:0] v,
                                                    input logic               neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// The dividend shifts out of the quotient register into the partial remainder.
module muldiv_divider
  import muldiv_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [`REG_LEN-1:0] dividend,
  input  logic [`REG_LEN-1:0] divisor,
  output logic [`REG_LEN-1:0] quotient,
  output logic [`REG_LEN-1:0] remainder
);

  localparam int W = `REG_LEN;

  logic [W-1:0] divisor_q;
  logic [W:0]   partial;
  logic [W:0]   diff;

  // The remainder always stays below the divisor, so W+1 bits hold the trial value.
  always_comb begin
    partial = {remainder, quotient[W-1]};
    diff    = partial - {1'b0, divisor_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      divisor_q <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      divisor_q <= divisor;
    end else if (step) begin
      if (!diff[W]) begin
        remainder <= diff[W-1:0];
        quotient  <= {quotient[W-2:0], 1'b1};
      end else begin
        remainder <= partial[W-1:0];
        quotient  <= {quotient[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a start/busy/done handshake.
// Divide ops are built only when RYSY_DIV_EN is defined; otherwise they complete at once with no write.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int ADDR_LEN = 5,
  parameter int CYCLES   = MULDIV_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          funct3,
  input  logic [`REG_LEN-1:0] rs1_d,
  input  logic [`REG_LEN-1:0] rs2_d,
  input  logic [ADDR_LEN-1:0] rd_in,
  output logic                busy,
  output logic                done,
  output logic [ADDR_LEN-1:0] rd,
  output logic [`REG_LEN-1:0] rd_d,
  output logic                reg_wr
);

  localparam int            W    = `REG_LEN;
  localparam int            CW   = $clog2(CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES);

  md_state_e state, state_n;

  logic [CW-1:0]       iter;
  logic [2:0]          op;
  logic [ADDR_LEN-1:0] rd_q;
  logic                neg;
  logic [2*W-1:0]      acc;
  logic [2*W-1:0]      mcand;
  logic [W-1:0]        mplier;
  logic [W-1:0]        result;

  logic           a_signed, b_signed, sa, sb, start_legal, op_legal;
  logic [W-1:0]   mag_a, mag_b;
  logic [2*W-1:0] prod;
  logic [W-1:0]   fixed_res;
  logic [W-1:0]   done_val;

  assign a_signed = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = funct3[2] ? !funct3[0] : !funct3[1];
  assign sa       = a_signed & rs1_d[W-1];
  assign sb       = b_signed & rs2_d[W-1];
  assign mag_a    = magnitude(rs1_d, sa);
  assign mag_b    = magnitude(rs2_d, sb);

`ifdef RYSY_DIV_EN
  logic         rem_neg;
  logic         div_zero;
  logic         div_ovf;
  logic [W-1:0] a_raw;
  logic [W-1:0] quotient, remainder;

  assign start_legal = 1'b1;
  assign op_legal    = 1'b1;

  muldiv_divider u_divider (
    .clk      (clk),
    .rst      (rst),
    .load     (state == MD_IDLE && start),
    .step     (state == MD_CALC && iter != LAST && op[2]),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quotient),
    .remainder(remainder)
  );
`else
  assign start_legal = !funct3[2];
  assign op_legal    = !op[2];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      MD_IDLE: if (start) state_n = start_legal ? MD_CALC : MD_DONE;
      MD_CALC: if (iter == LAST) state_n = MD_DONE;
      MD_DONE: state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  // Sign fix-up is registered in the extra CALC cycle that follows the last iteration.
  always_comb begin
    prod      = neg ? -acc : acc;
    fixed_res = (op == MULDIV_MUL) ? prod[W-1:0] : prod[2*W-1:W];
`ifdef RYSY_DIV_EN
    if (op[2]) fixed_res = op[1] ? (rem_neg ? -remainder : remainder)
                                 : (neg ? -quotient : quotient);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter     <= '0;
      op       <= '0;
      rd_q     <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result   <= '0;
`ifdef RYSY_DIV_EN
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      a_raw    <= '0;
`endif
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          iter     <= '0;
          op       <= funct3;
          rd_q     <= rd_in;
          neg      <= sa ^ sb;
          acc      <= '0;
          mcand    <= {{W{1'b0}}, mag_a};
          mplier   <= mag_b;
`ifdef RYSY_DIV_EN
          rem_neg  <= sa;
          a_raw    <= rs1_d;
          div_zero <= (rs2_d == '0);
          div_ovf  <= funct3[2] && !funct3[0] &&
                      (rs1_d == {1'b1, {(W-1){1'b0}}}) && (rs2_d == '1);
`endif
        end
        MD_CALC: begin
          if (iter != LAST) begin
            iter   <= iter + 1'b1;
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            result <= fixed_res;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done_val = result;
`ifdef RYSY_DIV_EN
    if (op[2] && div_zero)     done_val = op[1] ? a_raw : '1;
    else if (op[2] && div_ovf) done_val = op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
`else
    if (op[2]) done_val = '0;
`endif
  end

  assign busy   = (state != MD_IDLE);
  assign done   = (state == MD_DONE);
  assign rd     = rd_q;
  assign rd_d   = done ? done_val : '0;
  assign reg_wr = done && op_legal && (rd_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model, per-cycle output compare.
// Expected latency and legality of divide ops follow whether RYSY_DIV_EN is defined.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_d, rs2_d;
  logic [4:0]  rd_in;
  logic        busy, done, reg_wr;
  logic [4:0]  rd;
  logic [31:0] rd_d;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rd;
    logic        wr;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  muldiv_unit #(.ADDR_LEN(5), .CYCLES(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .funct3(funct3),
    .rs1_d (rs1_d),
    .rs2_d (rs2_d),
    .rd_in (rd_in),
    .busy  (busy),
    .done  (done),
    .rd    (rd),
    .rd_d  (rd_d),
    .reg_wr(reg_wr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa  = longint'($signed(a));
    longint      sb  = longint'($signed(b));
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    logic [63:0] p;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] f);
`ifdef RYSY_DIV_EN
    return 1'b1;
`else
    return !f[2];
`endif
  endfunction

  // Compare process: every cycle outside reset, done-cycle outputs against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          cur = q.pop_front();
          check("latency", 64'(cyc - cur.start_cyc), 64'(cur.lat));
          check("rd", rd, cur.rd);
          check("rd_d", rd_d, cur.value);
          check("reg_wr", reg_wr, cur.wr);
          check("busy_done", busy, 1'b1);
        end
      end else begin
        check("rd_d_not_done", rd_d, 32'h0);
        check("reg_wr_not_done", reg_wr, 1'b0);
        if (q.size() != 0 && cyc >= q[0].start_cyc) check("busy_calc", busy, 1'b1);
      end
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit repulse);
    exp_t e;
    logic legal;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    legal       = is_legal(f);
    e.value     = legal ? model(f, a, b) : 32'h0;
    e.rd        = r;
    e.wr        = legal && (r != 0);
    e.lat       = legal ? 33 : 0;
    e.start_cyc = cyc + 1;
    q.push_back(e);
    funct3 = f; rs1_d = a; rs2_d = b; rd_in = r; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom); rs1_d = $urandom; rs2_d = $urandom; rd_in = 5'($urandom);
    if (repulse && legal) begin
      repeat (5) @(negedge clk);
      funct3 = 3'($urandom); rs1_d = $urandom; rs2_d = $urandom;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; rs1_d = 32'h0; rs2_d = 32'h0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_reg_wr", reg_wr, 1'b0);
    check("reset_rd", rd, 5'd0);
    check("reset_rd_d", rd_d, 32'h0);
    rst = 1'b0;

    check("pin_mul", model(3'd0, 32'd7, 32'd6), 32'd42);
    check("pin_mulh", model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
    check("pin_mulhu", model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("pin_div", model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem", model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_divu", model(3'd5, 32'd100, 32'd7), 32'd14);
    check("pin_divu_zero", model(3'd5, 32'h1234, 32'h0), 32'hFFFF_FFFF);
    check("pin_remu_zero", model(3'd7, 32'h1234, 32'h0), 32'h1234);
    check("pin_div_ovf", model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_rem_ovf", model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

    do_op(3'd0, 32'd7, 32'd6, 5'd5, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    do_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b0);
    do_op(3'd5, 32'h1234, 32'h0, 5'd8, 1'b0);
    do_op(3'd7, 32'h1234, 32'h0, 5'd9, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
    do_op(3'd0, 32'd123, 32'd456, 5'd12, 1'b1);
    do_op(3'd4, 32'd1000, 32'd7, 5'd13, 1'b1);
    do_op(3'd0, 32'd9, 32'd9, 5'd0, 1'b0);

    for (int n = 0; n < 150; n++)
      do_op(3'($urandom), rand_operand(), rand_operand(), 5'($urandom), ($urandom_range(0, 9) == 0));

    // Abort mid-calculation: no done may follow, then a fresh op must complete.
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    funct3 = 3'd0; rs1_d = 32'd11; rs2_d = 32'd13; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (40) @(negedge clk);
    do_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15, 1'b0);
    do_op(3'd7, 32'd1000, 32'd7, 5'd16, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
